// File: rtl/dvi_link_sequencer.sv
// Bring-up and fault-recovery sequencer for the DVI output path: qualifies both
// PLL locks, then releases the serializer reset followed by the pixel pipeline reset.
module dvi_link_sequencer #(
    parameter int LOCK_STABLE_CYCLES   = 1024,
    parameter int SER_RESET_CYCLES     = 16,
    parameter int TPG_DELAY_CYCLES     = 16,
    parameter int FAULT_HOLDOFF_CYCLES = 4096
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pll_lock,
    input  logic       pll_lock_ser,
    input  logic       restart,
    output logic       ser_reset,
    output logic       tpg_reset,
    output logic       link_up,
    output logic [7:0] fault_count,
    output logic [2:0] state
);

    // state     | meaning
    // WAIT_LOCK | resets held, waiting for both PLLs to lock
    // STABLE    | resets held, locks must stay high LOCK_STABLE_CYCLES
    // SER_RST   | resets held for SER_RESET_CYCLES after qualification
    // SER_RUN   | serializers running, pixel pipeline still in reset
    // RUN       | link up
    // FAULT     | resets held for FAULT_HOLDOFF_CYCLES, then re-arm
    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        STABLE    = 3'd1,
        SER_RST   = 3'd2,
        SER_RUN   = 3'd3,
        RUN       = 3'd4,
        FAULT     = 3'd5
    } state_t;

    localparam int MAX_AB = (LOCK_STABLE_CYCLES > SER_RESET_CYCLES) ? LOCK_STABLE_CYCLES : SER_RESET_CYCLES;
    localparam int MAX_CD = (TPG_DELAY_CYCLES > FAULT_HOLDOFF_CYCLES) ? TPG_DELAY_CYCLES : FAULT_HOLDOFF_CYCLES;
    localparam int MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW     = $clog2(MAX_P) + 1;

    localparam logic [CW-1:0] LS_LAST = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] SR_LAST = CW'(SER_RESET_CYCLES - 1);
    localparam logic [CW-1:0] TD_LAST = CW'(TPG_DELAY_CYCLES - 1);
    localparam logic [CW-1:0] FH_LAST = CW'(FAULT_HOLDOFF_CYCLES - 1);

    logic [1:0]    lock_meta;
    logic [1:0]    lock_sync;
    logic          locked;
    state_t        st;
    state_t        st_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          fault_inc;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lock_meta <= 2'b00;
            lock_sync <= 2'b00;
        end else begin
            lock_meta <= {pll_lock_ser, pll_lock};
            lock_sync <= lock_meta;
        end
    end

    assign locked = &lock_sync;

    // Lock loss outranks restart on the exits to FAULT so the fault is counted.
    always_comb begin
        st_nxt    = st;
        cnt_nxt   = cnt;
        fault_inc = 1'b0;
        case (st)
            WAIT_LOCK: begin
                if (locked) st_nxt = STABLE;
            end
            STABLE: begin
                cnt_nxt = cnt + CW'(1);
                if (!locked || restart) st_nxt = WAIT_LOCK;
                else if (cnt == LS_LAST) st_nxt = SER_RST;
            end
            SER_RST, SER_RUN, RUN: begin
                if (st != RUN) cnt_nxt = cnt + CW'(1);
                if (!locked) begin
                    st_nxt    = FAULT;
                    fault_inc = 1'b1;
                end else if (restart) begin
                    st_nxt = FAULT;
                end else if (st == SER_RST && cnt == SR_LAST) begin
                    st_nxt = SER_RUN;
                end else if (st == SER_RUN && cnt == TD_LAST) begin
                    st_nxt = RUN;
                end
            end
            FAULT: begin
                cnt_nxt = cnt + CW'(1);
                if (cnt == FH_LAST) st_nxt = WAIT_LOCK;
            end
            default: st_nxt = FAULT;
        endcase
        if (st_nxt != st) cnt_nxt = '0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            st          <= WAIT_LOCK;
            cnt         <= '0;
            ser_reset   <= 1'b1;
            tpg_reset   <= 1'b1;
            link_up     <= 1'b0;
            fault_count <= 8'd0;
        end else begin
            st          <= st_nxt;
            cnt         <= cnt_nxt;
            ser_reset   <= !(st_nxt == SER_RUN || st_nxt == RUN);
            tpg_reset   <= (st_nxt != RUN);
            link_up     <= (st_nxt == RUN);
            if (fault_inc && fault_count != 8'hFF) fault_count <= fault_count + 8'd1;
        end
    end

    assign state = st;

endmodule

// File: tb/tb_dvi_link_sequencer.sv
// Scoreboard bench for dvi_link_sequencer: expected (edge, outputs) entries are
// queued from the timing rules and compared as the DUT reaches each edge.
module tb_dvi_link_sequencer;

    localparam logic [2:0] S_WAIT = 3'd0;
    localparam logic [2:0] S_STAB = 3'd1;
    localparam logic [2:0] S_SRST = 3'd2;
    localparam logic [2:0] S_SRUN = 3'd3;
    localparam logic [2:0] S_RUN  = 3'd4;
    localparam logic [2:0] S_FLT  = 3'd5;

    typedef struct {
        int          e;
        logic [13:0] v;
        string       nm;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       pll_lock = 1'b0;
    logic       pll_lock_ser = 1'b0;
    logic       restart = 1'b0;
    logic       ser_reset;
    logic       tpg_reset;
    logic       link_up;
    logic [7:0] fault_count;
    logic [2:0] state;
    logic [13:0] obs;

    exp_t       sb[$];
    logic [7:0] fcq[$];
    int         n_checks = 0;
    int         n_pass = 0;

    dvi_link_sequencer #(
        .LOCK_STABLE_CYCLES  (8),
        .SER_RESET_CYCLES    (4),
        .TPG_DELAY_CYCLES    (4),
        .FAULT_HOLDOFF_CYCLES(6)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .pll_lock    (pll_lock),
        .pll_lock_ser(pll_lock_ser),
        .restart     (restart),
        .ser_reset   (ser_reset),
        .tpg_reset   (tpg_reset),
        .link_up     (link_up),
        .fault_count (fault_count),
        .state       (state)
    );

    always #5 clock = ~clock;

    assign obs = {state, ser_reset, tpg_reset, link_up, fault_count};

    function automatic logic [13:0] ev(input logic [2:0] s, input logic sr, input logic tr,
                                       input logic lu, input logic [7:0] fc);
        return {s, sr, tr, lu, fc};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_checks++;
        if (obs !== ev(S_WAIT, 1, 1, 0, 0))
            $display("FAIL reset_state: got %h want %h", obs, ev(S_WAIT, 1, 1, 0, 0));
        else n_pass++;
    endtask

    task automatic test_cold_bringup();
        exp_t x;
        sb.delete();
        sb.push_back('{2,  ev(S_WAIT, 1, 1, 0, 0), "cold_wait"});
        sb.push_back('{3,  ev(S_STAB, 1, 1, 0, 0), "cold_stable"});
        sb.push_back('{10, ev(S_STAB, 1, 1, 0, 0), "cold_stable_last"});
        sb.push_back('{11, ev(S_SRST, 1, 1, 0, 0), "cold_ser_rst"});
        sb.push_back('{14, ev(S_SRST, 1, 1, 0, 0), "cold_ser_rst_last"});
        sb.push_back('{15, ev(S_SRUN, 0, 1, 0, 0), "cold_ser_run"});
        sb.push_back('{18, ev(S_SRUN, 0, 1, 0, 0), "cold_ser_run_last"});
        sb.push_back('{19, ev(S_RUN,  0, 0, 1, 0), "cold_run"});
        @(negedge clock);
        reset = 1'b0;
        pll_lock = 1'b1;
        pll_lock_ser = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (sb.size() > 0 && sb[0].e == k) begin
                x = sb.pop_front();
                n_checks++;
                if (obs !== x.v) $display("FAIL %s edge %0d: got %h want %h", x.nm, k, obs, x.v);
                else n_pass++;
            end
        end
        while (sb.size() > 0) begin
            x = sb.pop_front();
            n_checks++;
            $display("FAIL %s: edge %0d never reached, want %h", x.nm, x.e, x.v);
        end
    endtask

    task automatic test_glitch_stable();
        exp_t x;
        sb.delete();
        sb.push_back('{9,  ev(S_STAB, 1, 1, 0, 0), "glitch_still_stable"});
        sb.push_back('{10, ev(S_WAIT, 1, 1, 0, 0), "glitch_back_wait"});
        sb.push_back('{12, ev(S_WAIT, 1, 1, 0, 0), "glitch_wait_hold"});
        sb.push_back('{13, ev(S_STAB, 1, 1, 0, 0), "glitch_restable"});
        sb.push_back('{20, ev(S_STAB, 1, 1, 0, 0), "glitch_full_qual"});
        sb.push_back('{21, ev(S_SRST, 1, 1, 0, 0), "glitch_ser_rst"});
        sb.push_back('{25, ev(S_SRUN, 0, 1, 0, 0), "glitch_ser_run"});
        sb.push_back('{29, ev(S_RUN,  0, 0, 1, 0), "glitch_run"});
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (k < 25) begin
                n_checks++;
                if (ser_reset !== 1'b1) $display("FAIL glitch_ser_early edge %0d: got %b want 1", k, ser_reset);
                else n_pass++;
            end
            if (sb.size() > 0 && sb[0].e == k) begin
                x = sb.pop_front();
                n_checks++;
                if (obs !== x.v) $display("FAIL %s edge %0d: got %h want %h", x.nm, k, obs, x.v);
                else n_pass++;
            end
            if (k == 7) pll_lock_ser = 1'b0;
            if (k == 10) pll_lock_ser = 1'b1;
        end
        while (sb.size() > 0) begin
            x = sb.pop_front();
            n_checks++;
            $display("FAIL %s: edge %0d never reached, want %h", x.nm, x.e, x.v);
        end
    endtask

    task automatic test_lock_loss_run();
        exp_t x;
        sb.delete();
        sb.push_back('{2,  ev(S_RUN,  0, 0, 1, 0), "loss_still_run"});
        sb.push_back('{3,  ev(S_FLT,  1, 1, 0, 1), "loss_fault"});
        sb.push_back('{8,  ev(S_FLT,  1, 1, 0, 1), "loss_fault_last"});
        sb.push_back('{9,  ev(S_WAIT, 1, 1, 0, 1), "loss_rearm"});
        sb.push_back('{27, ev(S_SRUN, 0, 1, 0, 1), "loss_ser_run"});
        sb.push_back('{28, ev(S_RUN,  0, 0, 1, 1), "loss_run_again"});
        pll_lock = 1'b0;
        for (int k = 1; k <= 28; k++) begin
            tick();
            if (sb.size() > 0 && sb[0].e == k) begin
                x = sb.pop_front();
                n_checks++;
                if (obs !== x.v) $display("FAIL %s edge %0d: got %h want %h", x.nm, k, obs, x.v);
                else n_pass++;
            end
            if (k == 9) pll_lock = 1'b1;
        end
        while (sb.size() > 0) begin
            x = sb.pop_front();
            n_checks++;
            $display("FAIL %s: edge %0d never reached, want %h", x.nm, x.e, x.v);
        end
    endtask

    task automatic test_restart();
        exp_t x;
        sb.delete();
        sb.push_back('{1,  ev(S_FLT,  1, 1, 0, 1), "rst_pulse_fault"});
        sb.push_back('{7,  ev(S_WAIT, 1, 1, 0, 1), "rst_pulse_rearm"});
        sb.push_back('{8,  ev(S_STAB, 1, 1, 0, 1), "rst_pulse_stable"});
        sb.push_back('{24, ev(S_RUN,  0, 0, 1, 1), "rst_pulse_run"});
        restart = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            tick();
            if (sb.size() > 0 && sb[0].e == k) begin
                x = sb.pop_front();
                n_checks++;
                if (obs !== x.v) $display("FAIL %s edge %0d: got %h want %h", x.nm, k, obs, x.v);
                else n_pass++;
            end
            if (k == 1) restart = 1'b0;
        end
        sb.push_back('{2,  ev(S_RUN,  0, 0, 1, 1), "both_still_run"});
        sb.push_back('{3,  ev(S_FLT,  1, 1, 0, 2), "both_fault_inc"});
        sb.push_back('{9,  ev(S_WAIT, 1, 1, 0, 2), "both_rearm"});
        sb.push_back('{10, ev(S_STAB, 1, 1, 0, 2), "wait_restart_ignored"});
        sb.push_back('{26, ev(S_RUN,  0, 0, 1, 2), "both_run_again"});
        pll_lock = 1'b0;
        for (int k = 1; k <= 26; k++) begin
            tick();
            if (sb.size() > 0 && sb[0].e == k) begin
                x = sb.pop_front();
                n_checks++;
                if (obs !== x.v) $display("FAIL %s edge %0d: got %h want %h", x.nm, k, obs, x.v);
                else n_pass++;
            end
            if (k == 2) restart = 1'b1;
            if (k == 3) begin
                restart = 1'b0;
                pll_lock = 1'b1;
            end
            if (k == 9) restart = 1'b1;
            if (k == 10) restart = 1'b0;
        end
        while (sb.size() > 0) begin
            x = sb.pop_front();
            n_checks++;
            $display("FAIL %s: edge %0d never reached, want %h", x.nm, x.e, x.v);
        end
    endtask

    task automatic test_saturation();
        int         exp_fc = 2;
        int         waited;
        logic [7:0] want;
        fcq.delete();
        for (int i = 0; i < 260; i++) begin
            pll_lock = 1'b0;
            exp_fc = (exp_fc >= 255) ? 255 : exp_fc + 1;
            fcq.push_back(8'(exp_fc));
            waited = 0;
            while (state !== S_FLT && waited < 10) begin
                tick();
                waited++;
            end
            want = fcq.pop_front();
            n_checks++;
            if (state !== S_FLT) begin
                $display("FAIL sat_fault_timeout iter %0d: state %0d want %0d", i, state, S_FLT);
                break;
            end
            if (fault_count !== want) $display("FAIL sat_count iter %0d: got %0d want %0d", i, fault_count, want);
            else n_pass++;
            pll_lock = 1'b1;
            waited = 0;
            while (state !== S_RUN && waited < 40) begin
                tick();
                waited++;
            end
            if (state !== S_RUN) begin
                n_checks++;
                $display("FAIL sat_run_timeout iter %0d: state %0d want %0d", i, state, S_RUN);
                break;
            end
        end
        n_checks++;
        if (fault_count !== 8'd255) $display("FAIL sat_final: got %0d want 255", fault_count);
        else n_pass++;
    endtask

    task automatic test_async_reset_run();
        exp_t x;
        sb.delete();
        sb.push_back('{2,  ev(S_WAIT, 1, 1, 0, 0), "arst_wait"});
        sb.push_back('{3,  ev(S_STAB, 1, 1, 0, 0), "arst_stable"});
        sb.push_back('{18, ev(S_SRUN, 0, 1, 0, 0), "arst_ser_run"});
        sb.push_back('{19, ev(S_RUN,  0, 0, 1, 0), "arst_run"});
        n_checks++;
        if (state !== S_RUN) $display("FAIL arst_precond: state %0d want %0d", state, S_RUN);
        else n_pass++;
        #3;
        reset = 1'b1;
        #1;
        n_checks++;
        if (obs !== ev(S_WAIT, 1, 1, 0, 0))
            $display("FAIL arst_immediate: got %h want %h", obs, ev(S_WAIT, 1, 1, 0, 0));
        else n_pass++;
        #1;
        reset = 1'b0;
        for (int k = 1; k <= 19; k++) begin
            tick();
            if (sb.size() > 0 && sb[0].e == k) begin
                x = sb.pop_front();
                n_checks++;
                if (obs !== x.v) $display("FAIL %s edge %0d: got %h want %h", x.nm, k, obs, x.v);
                else n_pass++;
            end
        end
        while (sb.size() > 0) begin
            x = sb.pop_front();
            n_checks++;
            $display("FAIL %s: edge %0d never reached, want %h", x.nm, x.e, x.v);
        end
    endtask

    initial begin
        test_reset();
        test_cold_bringup();
        test_glitch_stable();
        test_lock_loss_run();
        test_restart();
        test_saturation();
        test_async_reset_run();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dvi_link_sequencer.md
# dvi_link_sequencer

Bring-up and fault-recovery controller for the DVI output path. It watches the two PLL lock signals (pixel PLL and serializer PLL) and sequences the reset release, serializers first and then the pixel pipeline (test pattern generator, TMDS encoder). On lock loss or a soft restart request it drops back to reset. It runs on the free-running board clock; its reset outputs feed the per-domain `reset_seq` instances in the pixel clock domain.

## Interface
Parameters:
- `LOCK_STABLE_CYCLES`, default 1024: cycles both locks must stay high before the sequence proceeds; ≥1.
- `SER_RESET_CYCLES`, default 16: cycles `ser_reset` is held after lock is qualified; ≥1.
- `TPG_DELAY_CYCLES`, default 16: cycles between `ser_reset` release and `tpg_reset` release; ≥1.
- `FAULT_HOLDOFF_CYCLES`, default 4096: cycles spent in FAULT before re-arming; ≥1.

Ports:
- `clock`, in, 1: board clock. This is the only clock.
- `reset`, in, 1: reset, asynchronous and active-high.
- `pll_lock`, in, 1: pixel PLL lock. Asynchronous to `clock`.
- `pll_lock_ser`, in, 1: serializer PLL lock. Asynchronous to `clock`.
- `restart`, in, 1: soft restart request, a synchronous single-cycle pulse.
- `ser_reset`, out, 1: reset for the OSER10 serializers. High means held in reset.
- `tpg_reset`, out, 1: reset for the TPG and `dvi_out`. High means held in reset.
- `link_up`, out, 1: high only in RUN.
- `fault_count`, out, 8: count of lock-loss faults, saturating.
- `state`, out, 3: current state code, for debug and LEDs.

## Operation
- Synchronizers:
  - `pll_lock` and `pll_lock_ser` each pass through a 2-FF synchronizer. Both stages reset to 0.
  - `locked` = AND of the two synchronized outputs.
- State codes: WAIT_LOCK=0, STABLE=1, SER_RST=2, SER_RUN=3, RUN=4, FAULT=5. Codes 6 and 7 are illegal and go to FAULT without incrementing `fault_count`.
- WAIT_LOCK:
  - `ser_reset`=1, `tpg_reset`=1.
  - If `locked`, go to STABLE and clear `cnt`.
  - `restart` is ignored.
- STABLE:
  - Resets are held. `cnt` increments each cycle.
  - If `!locked`, go to WAIT_LOCK. This is not a fault; `fault_count` is unchanged.
  - When `cnt` == LOCK_STABLE_CYCLES-1, go to SER_RST and clear `cnt`.
  - `restart` goes to WAIT_LOCK.
- SER_RST:
  - Resets are held for SER_RESET_CYCLES cycles.
  - Then go to SER_RUN.
- SER_RUN:
  - `ser_reset`=0, `tpg_reset`=1, for TPG_DELAY_CYCLES cycles.
  - Then go to RUN.
- RUN:
  - `ser_reset`=0, `tpg_reset`=0, `link_up`=1.
  - Stays until `!locked` or `restart`.
- Exits to FAULT from SER_RST, SER_RUN or RUN:
  - On `!locked`: go to FAULT and increment `fault_count`, saturating at 255.
  - On `restart` alone: go to FAULT with no increment.
  - If both occur in the same cycle, treat it as lock loss (increment).
- FAULT:
  - Resets are held. Stay for FAULT_HOLDOFF_CYCLES cycles regardless of `locked` or `restart`.
  - Then go to WAIT_LOCK.
- Counter:
  - One shared counter `cnt`, width `$clog2(max parameter)+1`.
  - Cleared on every state change. Never wraps within a state.
- Reset values:
  - state = WAIT_LOCK, `ser_reset`=1, `tpg_reset`=1, `link_up`=0, `fault_count`=0, `cnt`=0.
  - Synchronizers = 0.
  - Asserting `reset` in any state forces these values immediately. No fault is counted.

## Timing
- All outputs are registered and decoded from next-state, so each output changes on the same edge that the state enters.
- Lock input latency: a lock rising between edges 0 and 1 makes `locked` visible after edge 2, and STABLE is entered at edge 3.
- State residency: each counted state lasts exactly its parameter in cycles.
- Lock-loss detection: at most 3 edges from lock falling to FAULT. `ser_reset` and `tpg_reset` rise on that same edge.
- `restart` sampled in cycle n causes the state change at edge n+1.
- `fault_count` updates on the FAULT entry edge.

## Test plan
Parameters for all scenarios: LOCK_STABLE_CYCLES=8, SER_RESET_CYCLES=4, TPG_DELAY_CYCLES=4, FAULT_HOLDOFF_CYCLES=6.

- **Cold bring-up.** Release `reset`, then raise both locks before edge 1.
  - STABLE at edge 3, SER_RST at edge 11.
  - `ser_reset` falls at edge 15.
  - `tpg_reset` falls and `link_up` rises at edge 19.
  - `fault_count`=0.
- **Glitch in STABLE.** Drop `pll_lock_ser` for 3 cycles at STABLE cycle 5.
  - Returns to WAIT_LOCK; `fault_count`=0.
  - After the lock returns, the full 8-cycle qualification restarts.
  - `ser_reset` is never released early.
- **Lock loss in RUN.** Drop `pll_lock` while in RUN.
  - FAULT within 3 edges; both resets high and `link_up`=0 on that edge; `fault_count`=1.
  - 6 cycles in FAULT, then WAIT_LOCK.
  - With locks high, RUN again 19 edges after the WAIT_LOCK re-entry edge.
- **Restart handling.**
  - `restart` pulse in RUN: FAULT, `fault_count` unchanged.
  - `restart` plus lock loss in the same cycle: `fault_count` +1.
  - `restart` in WAIT_LOCK: no effect.
- **Saturation.** 260 lock-loss cycles through RUN leave `fault_count`=255, never 0 or 4.
- **Async reset mid-RUN.** Pulse `reset` between clock edges.
  - All outputs go to reset values before the next edge; `fault_count`=0.
  - With locks held high, RUN is reached 19 edges after reset release.
